led_matrix_scanner: RTL and testbench

//  Consumer end of the display_data bus that full_display_decoder produces. Takes the flat

---
 rtl/led_matrix_scanner_pkg.sv | 16 +
 rtl/led_matrix_scanner_scan_tick_gen.sv | 34 +++
 rtl/led_matrix_scanner.sv | 96 +++++++++
 tb/tb_led_matrix_scanner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/led_matrix_scanner_pkg.sv
// Shared defaults for the LED matrix path (also the frame geometry used by the display decoders).
// Column c of a frame occupies bits [c*COLUNE_SIZE +: COLUNE_SIZE]; column 0 sits in the LSBs.
package led_matrix_scanner_pkg;

  localparam int unsigned COLUNE_SIZE_DEF   = 7;
  localparam int unsigned TOTAL_COLUNES_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF    = COLUNE_SIZE_DEF * TOTAL_COLUNES_DEF;
  localparam int unsigned CLK_DIV_DEF       = 50000;
  localparam int unsigned BLANK_CYCLES_DEF  = 500;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_tick_gen.sv
// Column-slot prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each slot.
module scan_tick_gen
  import led_matrix_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  output logic [width_of(CLK_DIV)-1:0] o_div_cnt,
  output logic                         o_slot_end
);

  localparam int unsigned DIV_W = width_of(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_slot_end;

  assign w_slot_end = (r_div_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_div_cnt  = r_div_cnt;
  assign o_slot_end = w_slot_end;

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexes a column-packed frame onto a TOTAL_COLUNES x COLUNE_SIZE LED matrix.
// A shadow copy is taken only at frame boundaries so a scan never mixes two frames.
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned COLUNE_SIZE   = COLUNE_SIZE_DEF,
  parameter int unsigned TOTAL_COLUNES = TOTAL_COLUNES_DEF,
  parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
  parameter int unsigned BLANK_CYCLES  = BLANK_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    display_data,
  input  logic                     frame_valid,
  input  logic                     enable,
  output logic [TOTAL_COLUNES-1:0] column_n,
  output logic [COLUNE_SIZE-1:0]   row,
  output logic                     frame_done
);

  localparam int unsigned DIV_W = width_of(CLK_DIV);
  localparam int unsigned COL_W = width_of(TOTAL_COLUNES);
  localparam logic [COL_W-1:0]         LAST_COL = COL_W'(TOTAL_COLUNES - 1);
  localparam logic [TOTAL_COLUNES-1:0] COL0_SEL = TOTAL_COLUNES'(1);

  generate
    if (DATA_WIDTH != TOTAL_COLUNES * COLUNE_SIZE) begin : g_bad_width
      $error("led_matrix_scanner: DATA_WIDTH must equal TOTAL_COLUNES*COLUNE_SIZE");
    end
    if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
      $error("led_matrix_scanner: BLANK_CYCLES must be smaller than CLK_DIV");
    end
    if (CLK_DIV < 2) begin : g_bad_div
      $error("led_matrix_scanner: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0]         w_div_cnt;
  logic                     w_slot_end;
  logic                     w_last_col;
  logic                     w_unblanked;
  logic [COLUNE_SIZE-1:0]   w_cols [TOTAL_COLUNES];

  logic [COL_W-1:0]         r_col_idx;
  logic [DATA_WIDTH-1:0]    r_shadow;
  logic [TOTAL_COLUNES-1:0] r_column_n;
  logic [COLUNE_SIZE-1:0]   r_row;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk      (clk),
    .i_reset    (reset),
    .o_div_cnt  (w_div_cnt),
    .o_slot_end (w_slot_end)
  );

  genvar g_c;
  generate
    for (g_c = 0; g_c < TOTAL_COLUNES; g_c++) begin : g_col_slice
      assign w_cols[g_c] = r_shadow[g_c*COLUNE_SIZE +: COLUNE_SIZE];
    end
    // Rows stay off for the first BLANK_CYCLES of a slot so the previous column cannot ghost.
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_unblanked = 1'b1;
    end else begin : g_blank
      assign w_unblanked = (w_div_cnt >= DIV_W'(BLANK_CYCLES));
    end
  endgenerate

  assign w_last_col = (r_col_idx == LAST_COL);
  assign frame_done = w_slot_end && w_last_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_idx  <= '0;
      r_shadow   <= '0;
      r_column_n <= '1;
      r_row      <= '0;
    end else begin
      if (w_slot_end) begin
        r_col_idx <= w_last_col ? '0 : r_col_idx + 1'b1;
        if (w_last_col && frame_valid) begin
          r_shadow <= display_data;
        end
      end
      r_column_n <= enable ? ~(COL0_SEL << r_col_idx) : '1;
      r_row      <= (enable && w_unblanked) ? w_cols[r_col_idx] : '0;
    end
  end

  assign column_n = r_column_n;
  assign row      = r_row;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner at CLK_DIV=4, BLANK_CYCLES=1 (20-cycle frames).
module tb_led_matrix_scanner;

  logic        clk;
  logic        reset;
  logic [34:0] display_data;
  logic        frame_valid;
  logic        enable;
  logic [4:0]  column_n;
  logic [6:0]  row;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [34:0] D1 = 35'h4_0201_0081;
  localparam logic [34:0] D2 = {7'h03, 7'h55, 7'h2A, 7'h00, 7'h7F};
  localparam logic [34:0] D3 = {7'h11, 7'h22, 7'h44, 7'h08, 7'h70};

  led_matrix_scanner #(
    .DATA_WIDTH    (35),
    .COLUNE_SIZE   (7),
    .TOTAL_COLUNES (5),
    .CLK_DIV       (4),
    .BLANK_CYCLES  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .display_data (display_data),
    .frame_valid  (frame_valid),
    .enable       (enable),
    .column_n     (column_n),
    .row          (row),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] act, input logic [34:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One output slot (4 cycles) of column col; dark[i]=1 drives enable low ahead of cycle i.
  task automatic run_slot(input int col, input logic [6:0] exp_row, input logic [3:0] dark);
    logic [4:0] e_col;
    logic [6:0] e_row;
    logic       e_done;
    for (int i = 0; i < 4; i++) begin
      enable = !dark[i];
      @(posedge clk);
      #1;
      e_col  = dark[i] ? 5'b11111 : ~(5'b00001 << col);
      e_row  = (dark[i] || i == 0) ? 7'h00 : exp_row;
      e_done = (col == 4) && (i == 2);
      check($sformatf("col%0d_cyc%0d column_n", col, i), {30'd0, column_n}, {30'd0, e_col});
      check($sformatf("col%0d_cyc%0d row", col, i), {28'd0, row}, {28'd0, e_row});
      check($sformatf("col%0d_cyc%0d frame_done", col, i), {34'd0, frame_done}, {34'd0, e_done});
    end
  endtask

  task automatic run_frame(input logic [34:0] exp_frame);
    for (int c = 0; c < 5; c++) begin
      run_slot(c, exp_frame[c*7 +: 7], 4'b0000);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " column_n"}, {30'd0, column_n}, {30'd0, 5'b11111});
    check({tag, " row"}, {28'd0, row}, 35'd0);
    check({tag, " frame_done"}, {34'd0, frame_done}, 35'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    frame_valid  = 1'b1;
    display_data = D1;

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_reset_outputs($sformatf("reset%0d", k));
    end
    reset = 1'b0;

    // Frame 0: shadow still empty; first cycle after reset held dark.
    run_slot(0, 7'h00, 4'b0001);
    run_slot(1, 7'h00, 4'b0000);
    run_slot(2, 7'h00, 4'b0000);
    run_slot(3, 7'h00, 4'b0000);
    run_slot(4, 7'h00, 4'b0000);

    // Frame 1: D1 shown; new data arriving at col2 must not leak into this frame.
    run_slot(0, 7'h01, 4'b0000);
    run_slot(1, 7'h01, 4'b0000);
    display_data = D2;
    run_slot(2, 7'h04, 4'b0000);
    run_slot(3, 7'h10, 4'b0000);
    run_slot(4, 7'h40, 4'b0000);

    // Frame 2: D2; boundary at the end of this frame is not latched.
    run_slot(0, 7'h7F, 4'b0000);
    run_slot(1, 7'h00, 4'b0000);
    run_slot(2, 7'h2A, 4'b0000);
    display_data = D3;
    frame_valid  = 1'b0;
    run_slot(3, 7'h55, 4'b0000);
    run_slot(4, 7'h03, 4'b0000);

    // Frame 3: D2 repeats; frame_valid restored so D3 latches at the end.
    run_slot(0, 7'h7F, 4'b0000);
    frame_valid = 1'b1;
    run_slot(1, 7'h00, 4'b0000);
    run_slot(2, 7'h2A, 4'b0000);
    run_slot(3, 7'h55, 4'b0000);
    run_slot(4, 7'h03, 4'b0000);

    // Frame 4: D3 with enable low for six cycles spanning col1/col2.
    run_slot(0, 7'h70, 4'b0000);
    run_slot(1, 7'h08, 4'b1100);
    run_slot(2, 7'h44, 4'b1111);
    run_slot(3, 7'h22, 4'b0000);
    run_slot(4, 7'h11, 4'b0000);

    // Frame 5: reset pulsed partway through col3.
    run_slot(0, 7'h70, 4'b0000);
    run_slot(1, 7'h08, 4'b0000);
    run_slot(2, 7'h44, 4'b0000);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("pre_reset%0d column_n", i), {30'd0, column_n}, {30'd0, 5'b10111});
      check($sformatf("pre_reset%0d row", i), {28'd0, row}, (i == 0) ? 35'd0 : 35'h22);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;

    // Shadow cleared: a full dark frame, then D3 again from col0.
    run_frame(35'd0);
    run_slot(0, 7'h70, 4'b0000);
    run_slot(1, 7'h08, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
